// File: rtl/dir_input_ctrl.sv
// Four-button direction input: per-button sync + debounce, press-edge detect,
// priority encode, and a single-entry valid/ready hold stage with a move counter.
module dir_input_ctrl #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        up,
  input  logic        down,
  input  logic        right,
  input  logic        left,
  input  logic        dir_ready,
  output logic [2:0]  dir,
  output logic        dir_valid,
  output logic [15:0] moves
);

  localparam int unsigned NB = 4;
  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  logic [NB-1:0] raw;
  logic [NB-1:0] s1;
  logic [NB-1:0] s2;
  logic [NB-1:0] db;
  logic [NB-1:0] db_prev;
  logic [CW-1:0] cnt [NB];
  logic [NB-1:0] press;
  logic [2:0]    win_code;

  state_t      state;
  state_t      state_n;
  logic [2:0]  dir_n;
  logic        valid_n;
  logic [15:0] moves_n;

  // Bit 0 is the highest-priority button.
  assign raw = {left, right, down, up};

  // Synchronizers and debounce: db follows s2 only after DB_CYCLES straight cycles of disagreement.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= '0;
      s2      <= '0;
      db      <= '0;
      db_prev <= '0;
      for (int b = 0; b < NB; b++) cnt[b] <= '0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      db_prev <= db;
      for (int b = 0; b < NB; b++) begin
        if (s2[b] != db[b]) begin
          if (cnt[b] == CW'(DB_CYCLES - 1)) begin
            db[b]  <= s2[b];
            cnt[b] <= '0;
          end else begin
            cnt[b] <= cnt[b] + CW'(1);
          end
        end else begin
          cnt[b] <= '0;
        end
      end
    end
  end

  assign press = db & ~db_prev;

  always_comb begin
    win_code = 3'b000;
    if      (press[0]) win_code = 3'b001;
    else if (press[1]) win_code = 3'b010;
    else if (press[2]) win_code = 3'b011;
    else if (press[3]) win_code = 3'b100;
  end

  // Next-state and next-output logic; events seen while holding a move are dropped.
  always_comb begin
    state_n = state;
    dir_n   = dir;
    valid_n = dir_valid;
    moves_n = moves;
    case (state)
      IDLE: begin
        dir_n   = 3'b000;
        valid_n = 1'b0;
        if (|press) begin
          state_n = HOLD;
          dir_n   = win_code;
          valid_n = 1'b1;
        end
      end
      HOLD: begin
        if (dir_ready) begin
          state_n = IDLE;
          dir_n   = 3'b000;
          valid_n = 1'b0;
          moves_n = (moves == 16'hFFFF) ? moves : moves + 16'd1;
        end
      end
      default: begin
        state_n = IDLE;
        dir_n   = 3'b000;
        valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dir       <= 3'b000;
      dir_valid <= 1'b0;
      moves     <= 16'd0;
    end else begin
      state     <= state_n;
      dir       <= dir_n;
      dir_valid <= valid_n;
      moves     <= moves_n;
    end
  end

endmodule

// File: tb/tb_dir_input_ctrl.sv
// Bench for dir_input_ctrl: directed scenarios plus random button activity,
// checked every cycle against a behavioural model of the button/move rules.
module tb_dir_input_ctrl;

  localparam int unsigned DB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        up, down, right, left;
  logic        dir_ready;
  logic [2:0]  dir;
  logic        dir_valid;
  logic [15:0] moves;

  int checks = 0;
  int errors = 0;

  // Model state: sync stages, debounced level, previous level, run length per button.
  bit m_s1 [4];
  bit m_s2 [4];
  bit m_db [4];
  bit m_dbp[4];
  int m_cnt[4];
  bit m_pend;
  int m_dir;
  int m_moves;

  dir_input_ctrl #(.DB_CYCLES(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .up        (up),
    .down      (down),
    .right     (right),
    .left      (left),
    .dir_ready (dir_ready),
    .dir       (dir),
    .dir_valid (dir_valid),
    .moves     (moves)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_tick();
    bit raw[4];
    int ev;
    raw = '{up, down, right, left};
    if (rst) begin
      for (int b = 0; b < 4; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_db[b] = 0; m_dbp[b] = 0; m_cnt[b] = 0;
      end
      m_pend = 0; m_dir = 0; m_moves = 0;
    end else begin
      ev = -1;
      for (int b = 0; b < 4; b++)
        if (ev < 0 && m_db[b] && !m_dbp[b]) ev = b;
      if (!m_pend) begin
        if (ev >= 0) begin
          m_pend = 1;
          m_dir  = ev + 1;
        end
      end else if (dir_ready) begin
        m_pend = 0;
        m_dir  = 0;
        if (m_moves < 65535) m_moves++;
      end
      for (int b = 0; b < 4; b++) begin
        m_dbp[b] = m_db[b];
        if (m_s2[b] != m_db[b]) begin
          m_cnt[b]++;
          if (m_cnt[b] == int'(DB)) begin
            m_db[b]  = m_s2[b];
            m_cnt[b] = 0;
          end
        end else begin
          m_cnt[b] = 0;
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = raw[b];
      end
    end
  endtask

  task automatic check_outs();
    chk("dir", 32'(dir), 32'(m_dir));
    chk("dir_valid", 32'(dir_valid), 32'(m_pend));
    chk("moves", 32'(moves), 32'(m_moves));
  endtask

  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
    check_outs();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until dir_valid rises; returns the number of edges taken (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    while (dir_valid !== 1'b1 && n < 30) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    int hold[4];
    bit lvl[4];

    rst = 1'b1; up = 0; down = 0; right = 0; left = 0; dir_ready = 0;
    idle_steps(2);
    chk("reset_dir_valid", 32'(dir_valid), 32'd0);

    // Up held from the first post-reset edge: valid after DB+3 edges, then stable.
    rst = 1'b0; up = 1'b1;
    wait_valid(n);
    chk("latency_up", 32'(n), 32'(DB + 3));
    chk("dir_up", 32'(dir), 32'd1);
    idle_steps(20);
    chk("hold_stable_dir", 32'(dir), 32'd1);
    chk("hold_moves0", 32'(moves), 32'd0);

    // Accept, then keep up held: no second event.
    dir_ready = 1'b1; step(); dir_ready = 1'b0;
    chk("accept_moves1", 32'(moves), 32'd1);
    idle_steps(20);
    chk("held_no_repeat", 32'(dir_valid), 32'd0);
    up = 1'b0; idle_steps(15);

    // Short glitch on left is filtered.
    left = 1'b1; idle_steps(3); left = 1'b0;
    idle_steps(15);
    chk("glitch_filtered", 32'(dir_valid), 32'd0);

    // Simultaneous down+right: down wins, right discarded.
    down = 1'b1; right = 1'b1;
    wait_valid(n);
    chk("prio_down", 32'(dir), 32'd2);
    dir_ready = 1'b1; step(); dir_ready = 1'b0;
    idle_steps(15);
    chk("no_right_after", 32'(dir_valid), 32'd0);
    down = 1'b0; right = 1'b0; idle_steps(15);

    // Right held in HOLD; left's press event lands in the same cycle as dir_ready.
    right = 1'b1;
    wait_valid(n);
    chk("dir_right", 32'(dir), 32'd3);
    left = 1'b1;
    idle_steps(DB + 2);
    dir_ready = 1'b1; step(); dir_ready = 1'b0;
    chk("coincide_valid", 32'(dir_valid), 32'd0);
    idle_steps(10);
    chk("left_dropped", 32'(dir_valid), 32'd0);
    right = 1'b0; left = 1'b0; idle_steps(15);

    // Random button activity with random acceptance.
    for (int b = 0; b < 4; b++) begin
      hold[b] = $urandom_range(1, 12);
      lvl[b]  = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        hold[b]--;
        if (hold[b] <= 0) begin
          lvl[b]  = !lvl[b];
          hold[b] = $urandom_range(1, 12);
        end
      end
      up = lvl[0]; down = lvl[1]; right = lvl[2]; left = lvl[3];
      dir_ready = ($urandom_range(0, 3) == 0);
      step();
    end

    // Quiet down and drain any pending move.
    up = 0; down = 0; right = 0; left = 0; dir_ready = 1'b1;
    step();
    dir_ready = 1'b0;
    idle_steps(15);

    // Preload moves to FFFE across an idle edge, then check saturation.
    force dut.moves = 16'hFFFE;
    m_moves = 65534;
    model_tick();
    @(posedge clk);
    #1;
    release dut.moves;
    check_outs();
    up = 1'b1;
    wait_valid(n);
    dir_ready = 1'b1; step(); dir_ready = 1'b0;
    chk("moves_ffff", 32'(moves), 32'hFFFF);
    up = 1'b0; idle_steps(15);
    up = 1'b1;
    wait_valid(n);
    dir_ready = 1'b1; step(); dir_ready = 1'b0;
    chk("moves_saturated", 32'(moves), 32'hFFFF);
    up = 1'b0; idle_steps(15);

    // Reset while holding a move; the held button counts as a new press afterwards.
    down = 1'b1;
    wait_valid(n);
    chk("pre_reset_hold", 32'(dir_valid), 32'd1);
    rst = 1'b1; step();
    chk("rst_dir", 32'(dir), 32'd0);
    chk("rst_valid", 32'(dir_valid), 32'd0);
    chk("rst_moves", 32'(moves), 32'd0);
    rst = 1'b0;
    wait_valid(n);
    chk("latency_after_reset", 32'(n), 32'(DB + 3));
    chk("dir_down_after_reset", 32'(dir), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
